// File: rtl/muldiv.sv
// muldiv: iterative multiply/divide sequencer owning the HI/LO register pair.
// Executes MULT, MULTU, DIV, DIVU (32 iterations + 1 fix-up cycle) and MTHI/MTLO
// (single cycle) on one shared shift/add-subtract datapath.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - command strobe, sampled only while busy is low
//   op    - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a     - rs operand (multiplicand, dividend, MTHI/MTLO source)
//   b     - rt operand (multiplier, divisor)
//   busy  - high while a multiply/divide is in progress
//   hi    - HI register
//   lo    - LO register
module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    localparam logic [2:0] OpMthi = 3'b100;
    localparam logic [2:0] OpMtlo = 3'b101;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;      // product, or {remainder, quotient}
    logic [31:0] opd_q, opd_d;      // multiplicand or divisor magnitude
    logic [31:0] a_q, a_d;          // dividend as issued, for divide-by-zero
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;      // negate product / quotient
    logic        neg_rem_q, neg_rem_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        signed_op;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // op[0]=0 selects the signed variants of both multiply and divide.
    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && a[31]) ? (32'd0 - a) : a;
    assign abs_b     = (signed_op && b[31]) ? (32'd0 - b) : b;

    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
    assign rem_sh   = acc_q[63:31];
    assign div_diff = rem_sh - {1'b0, opd_q};

    assign prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
    assign quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (!op[2]) begin
                        is_div_d  = op[1];
                        neg_d     = signed_op && (a[31] ^ b[31]);
                        neg_rem_d = signed_op && a[31];
                        dbz_d     = (b == 32'd0);
                        a_d       = a;
                        cnt_d     = 5'd0;
                        state_d   = StCalc;
                        if (op[1]) begin
                            acc_d = {32'd0, abs_a};
                            opd_d = abs_b;
                        end else begin
                            acc_d = {32'd0, abs_b};
                            opd_d = abs_a;
                        end
                    end else if (op == OpMthi) begin
                        hi_d = a;
                    end else if (op == OpMtlo) begin
                        lo_d = a;
                    end
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    // Restoring step: keep the difference only if it did not go negative.
                    if (!div_diff[32]) begin
                        acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (dbz_q) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opd_q     <= 32'd0;
            a_q       <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv.
module tb_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command for one cycle; returns #1 after the accepting edge (cycle 1).
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count cycles with busy high (bounded) and note whether hi/lo moved meanwhile.
    task automatic wait_done(output int cyc, output bit changed);
        logic [31:0] h0, l0;
        h0      = hi;
        l0      = lo;
        cyc     = 0;
        changed = 1'b0;
        while (busy && cyc < 100) begin
            cyc++;
            if (hi !== h0 || lo !== l0) changed = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mult_neg;
        int cyc;
        bit chg;
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc, chg);
        n_tests++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL mult_busy_cycles: got %0d want 33", cyc);
        end
        n_tests++;
        if (chg !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_hold_during_busy: got changed=%b want 0", chg);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL mult_neg3x5: got hi=%h lo=%h want ffffffff/fffffff1", hi, lo);
        end
    endtask

    task automatic test_multu_max;
        int cyc;
        bit chg;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, chg);
        n_tests++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_max: got hi=%h lo=%h want fffffffe/00000001", hi, lo);
        end
    endtask

    task automatic test_mult_minint;
        int cyc;
        bit chg;
        issue(MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc, chg);
        n_tests++;
        if (hi !== 32'h4000_0000 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL mult_minint: got hi=%h lo=%h want 40000000/00000000", hi, lo);
        end
    endtask

    task automatic test_div;
        int cyc;
        bit chg;
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, chg);
        n_tests++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL div_busy_cycles: got %0d want 33", cyc);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg7by2: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
        end
        issue(DIVU, 32'd7, 32'd2);
        wait_done(cyc, chg);
        n_tests++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            n_fail++;
            $display("FAIL divu_7by2: got hi=%h lo=%h want 00000001/00000003", hi, lo);
        end
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, chg);
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: got hi=%h lo=%h want 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_div_by_zero;
        int cyc;
        bit chg;
        issue(DIV, 32'h0000_1234, 32'd0);
        wait_done(cyc, chg);
        n_tests++;
        if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_by_zero: got hi=%h lo=%h want 00001234/ffffffff", hi, lo);
        end
        issue(DIVU, 32'h0000_1234, 32'd0);
        wait_done(cyc, chg);
        n_tests++;
        if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL divu_by_zero: got hi=%h lo=%h want 00001234/ffffffff", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo;
        // lo still holds 0xFFFFFFFF from the divide-by-zero test
        issue(MTHI, 32'hCAFE_BABE, 32'd0);
        n_tests++;
        if (hi !== 32'hCAFE_BABE || lo !== 32'hFFFF_FFFF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: got hi=%h lo=%h busy=%b want cafebabe/ffffffff/0",
                     hi, lo, busy);
        end
        issue(MTLO, 32'h1357_9BDF, 32'd0);
        n_tests++;
        if (hi !== 32'hCAFE_BABE || lo !== 32'h1357_9BDF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b want cafebabe/13579bdf/0",
                     hi, lo, busy);
        end
        issue(3'b111, 32'h5555_5555, 32'd9);
        n_tests++;
        if (hi !== 32'hCAFE_BABE || lo !== 32'h1357_9BDF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL noop: got hi=%h lo=%h busy=%b want cafebabe/13579bdf/0",
                     hi, lo, busy);
        end
    endtask

    task automatic test_cmd_while_busy;
        int cyc;
        bit chg;
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = MTLO;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        op    = MULT;
        a     = 32'd3;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        // now in cycle 8, busy should remain through cycle 33
        wait_done(cyc, chg);
        n_tests++;
        if (cyc !== 26) begin
            n_fail++;
            $display("FAIL busy_ignore_cycles: got %0d want 26", cyc);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL busy_ignore_result: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_no_queue: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_op;
        int cyc;
        bit chg;
        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        op    = MULTU;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, chg);
        n_tests++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL after_reset_cycles: got %0d want 33", cyc);
        end
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            n_fail++;
            $display("FAIL after_reset_multu: got hi=%h lo=%h want 00000000/0000000c", hi, lo);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        op      = 3'b000;
        a       = 32'd0;
        b       = 32'd0;
        test_reset();
        test_mult_neg();
        test_multu_max();
        test_mult_minint();
        test_div();
        test_div_by_zero();
        test_mthi_mtlo();
        test_cmd_while_busy();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
